// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of one shared combinational ALU
// Accepts one operation at a time, drives the ALU from registers, and returns the captured result to the owner.
module alu_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_in1,
    input  logic [15:0] req0_in2,
    input  logic [2:0]  req0_mode,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_in1,
    input  logic [15:0] req1_in2,
    input  logic [2:0]  req1_mode,
    output logic [15:0] alu_in1,
    output logic [15:0] alu_in2,
    output logic [2:0]  alu_mode,
    input  logic [15:0] alu_out,
    input  logic [15:0] alu_flags,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [15:0] rsp0_data,
    output logic [15:0] rsp0_flags,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [15:0] rsp1_data,
    output logic [15:0] rsp1_flags,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   rr;
    logic   owner;
    logic   grant0;
    logic   grant1;
    logic   owner_rsp_ready;

    // Requester 1 wins a tie only in round-robin mode when the pointer names it.
    always_comb begin
        grant1 = req1_valid && (!req0_valid || ((FIXED_PRIO == 0) && rr));
        grant0 = req0_valid && !grant1;
    end

    assign req0_ready      = !rst && (state == IDLE) && grant0;
    assign req1_ready      = !rst && (state == IDLE) && grant1;
    assign busy            = (state != IDLE);
    assign owner_rsp_ready = owner ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr         <= 1'b0;
            owner      <= 1'b0;
            alu_in1    <= 16'h0000;
            alu_in2    <= 16'h0000;
            alu_mode   <= 3'd0;
            rsp0_valid <= 1'b0;
            rsp0_data  <= 16'h0000;
            rsp0_flags <= 16'h0000;
            rsp1_valid <= 1'b0;
            rsp1_data  <= 16'h0000;
            rsp1_flags <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0) begin
                        alu_in1  <= req0_in1;
                        alu_in2  <= req0_in2;
                        alu_mode <= req0_mode;
                        owner    <= 1'b0;
                        state    <= EXEC;
                    end else if (grant1) begin
                        alu_in1  <= req1_in1;
                        alu_in2  <= req1_in2;
                        alu_mode <= req1_mode;
                        owner    <= 1'b1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (owner) begin
                        rsp1_data  <= alu_out;
                        rsp1_flags <= alu_flags;
                        rsp1_valid <= 1'b1;
                    end else begin
                        rsp0_data  <= alu_out;
                        rsp0_flags <= alu_flags;
                        rsp0_valid <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (owner_rsp_ready) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        rr         <= ~owner;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
// Instance a is round-robin, instance b is fixed priority; both share stimulus.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 1'b0;
    logic [15:0] req0_in1 = 16'h0;
    logic [15:0] req0_in2 = 16'h0;
    logic [2:0]  req0_mode = 3'd0;
    logic        req1_valid = 1'b0;
    logic [15:0] req1_in1 = 16'h0;
    logic [15:0] req1_in2 = 16'h0;
    logic [2:0]  req1_mode = 3'd0;
    logic        rsp0_ready = 1'b0;
    logic        rsp1_ready = 1'b0;
    logic [15:0] alu_flags = 16'h0;

    logic        a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid, a_busy;
    logic [15:0] a_alu_in1, a_alu_in2, a_alu_out, a_rsp0_data, a_rsp0_flags, a_rsp1_data, a_rsp1_flags;
    logic [2:0]  a_alu_mode;
    logic        b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid, b_busy;
    logic [15:0] b_alu_in1, b_alu_in2, b_alu_out, b_rsp0_data, b_rsp0_flags, b_rsp1_data, b_rsp1_flags;
    logic [2:0]  b_alu_mode;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_model(input logic [15:0] x, input logic [15:0] y, input logic [2:0] m);
        case (m)
            3'd0: return x + y;
            3'd1: return x - y;
            3'd2: return x >> y[3:0];
            3'd3: return x << y[3:0];
            3'd4: return x & y;
            3'd5: return x | y;
            3'd6: return ~x;
            default: return x ^ y;
        endcase
    endfunction

    assign a_alu_out = alu_model(a_alu_in1, a_alu_in2, a_alu_mode);
    assign b_alu_out = alu_model(b_alu_in1, b_alu_in2, b_alu_mode);

    alu_arbiter #(.FIXED_PRIO(0)) dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(a_req0_ready), .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_mode(req0_mode),
        .req1_valid(req1_valid), .req1_ready(a_req1_ready), .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_mode(req1_mode),
        .alu_in1(a_alu_in1), .alu_in2(a_alu_in2), .alu_mode(a_alu_mode), .alu_out(a_alu_out), .alu_flags(alu_flags),
        .rsp0_valid(a_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(a_rsp0_data), .rsp0_flags(a_rsp0_flags),
        .rsp1_valid(a_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(a_rsp1_data), .rsp1_flags(a_rsp1_flags),
        .busy(a_busy)
    );

    alu_arbiter #(.FIXED_PRIO(1)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_mode(req0_mode),
        .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_mode(req1_mode),
        .alu_in1(b_alu_in1), .alu_in2(b_alu_in2), .alu_mode(b_alu_mode), .alu_out(b_alu_out), .alu_flags(alu_flags),
        .rsp0_valid(b_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(b_rsp0_data), .rsp0_flags(b_rsp0_flags),
        .rsp1_valid(b_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(b_rsp1_data), .rsp1_flags(b_rsp1_flags),
        .busy(b_busy)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rst = 1'b1;
        tick();
        #1;
        checks++; if (a_req0_ready !== 1'b0 || a_req1_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b%b exp=00", a_req0_ready, a_req1_ready); end
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
        checks++; if ({a_alu_in1, a_alu_in2, a_alu_mode} !== 35'd0) begin failures++; $display("FAIL reset_alu got=%h %h %h exp=0", a_alu_in1, a_alu_in2, a_alu_mode); end
        checks++; if ({a_rsp0_valid, a_rsp1_valid, a_rsp0_data, a_rsp0_flags, a_rsp1_data, a_rsp1_flags} !== 66'd0) begin failures++; $display("FAIL reset_rsp got=%b%b %h %h %h %h exp=0", a_rsp0_valid, a_rsp1_valid, a_rsp0_data, a_rsp0_flags, a_rsp1_data, a_rsp1_flags); end
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_single_op();
        req0_in1 = 16'h0003; req0_in2 = 16'h0004; req0_mode = 3'd0;
        alu_flags = 16'hA5A5;
        rsp0_ready = 1'b0;
        req0_valid = 1'b1;
        #1;
        checks++; if (a_req0_ready !== 1'b1 || a_req1_ready !== 1'b0) begin failures++; $display("FAIL single_ready got=%b%b exp=10", a_req0_ready, a_req1_ready); end
        tick();
        req0_valid = 1'b0;
        #1;
        checks++; if (a_alu_in1 !== 16'h0003 || a_alu_in2 !== 16'h0004 || a_alu_mode !== 3'd0) begin failures++; $display("FAIL single_alu_in got=%h %h %h exp=0003 0004 0", a_alu_in1, a_alu_in2, a_alu_mode); end
        checks++; if (a_busy !== 1'b1 || a_rsp0_valid !== 1'b0) begin failures++; $display("FAIL single_exec got busy=%b v=%b exp busy=1 v=0", a_busy, a_rsp0_valid); end
        tick();
        checks++; if (a_rsp0_valid !== 1'b1 || a_rsp0_data !== 16'h0007 || a_rsp1_valid !== 1'b0) begin failures++; $display("FAIL single_rsp got v=%b d=%h v1=%b exp v=1 d=0007 v1=0", a_rsp0_valid, a_rsp0_data, a_rsp1_valid); end
        checks++; if (a_rsp0_flags !== 16'hA5A5) begin failures++; $display("FAIL flags_pass got=%h exp=a5a5", a_rsp0_flags); end
        checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL single_busy_resp got=%b exp=1", a_busy); end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        checks++; if (a_rsp0_valid !== 1'b0 || a_busy !== 1'b0) begin failures++; $display("FAIL single_done got v=%b busy=%b exp 0 0", a_rsp0_valid, a_busy); end
        checks++; if (a_alu_in1 !== 16'h0003 || a_rsp0_data !== 16'h0007) begin failures++; $display("FAIL single_hold got in1=%h d=%h exp 0003 0007", a_alu_in1, a_rsp0_data); end
        alu_flags = 16'h0000;
    endtask

    task automatic test_contention();
        logic [15:0] exp;
        do_reset();
        req0_in1 = 16'h0010; req0_in2 = 16'h0001; req0_mode = 3'd0;
        req1_in1 = 16'h0020; req1_in2 = 16'h0001; req1_mode = 3'd7;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (a_req0_ready !== (k % 2 == 0) || a_req1_ready !== (k % 2 == 1)) begin failures++; $display("FAIL rr_grant op=%0d got=%b%b exp_owner=%0d", k, a_req0_ready, a_req1_ready, k % 2); end
            tick();
            tick();
            exp = (k % 2 == 0) ? 16'h0011 : 16'h0021;
            if (k % 2 == 0) begin
                checks++; if (a_rsp0_valid !== 1'b1 || a_rsp1_valid !== 1'b0 || a_rsp0_data !== exp) begin failures++; $display("FAIL rr_rsp op=%0d got v=%b%b d=%h exp v=10 d=%h", k, a_rsp0_valid, a_rsp1_valid, a_rsp0_data, exp); end
            end else begin
                checks++; if (a_rsp1_valid !== 1'b1 || a_rsp0_valid !== 1'b0 || a_rsp1_data !== exp) begin failures++; $display("FAIL rr_rsp op=%0d got v=%b%b d=%h exp v=01 d=%h", k, a_rsp0_valid, a_rsp1_valid, a_rsp1_data, exp); end
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_fixed_prio();
        int grants = 0;
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        for (int c = 0; c < 12; c++) begin
            checks++; if (b_req1_ready !== 1'b0) begin failures++; $display("FAIL fixed_no_req1 cycle=%0d got=%b exp=0", c, b_req1_ready); end
            if (b_req0_ready === 1'b1) grants++;
            tick();
        end
        checks++; if (grants !== 4) begin failures++; $display("FAIL fixed_req0_grants got=%0d exp=4", grants); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        req1_in1 = 16'h0005; req1_in2 = 16'h0002; req1_mode = 3'd1;
        req1_valid = 1'b1;
        tick();
        req0_valid = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            checks++; if (a_rsp1_valid !== 1'b1 || a_rsp1_data !== 16'h0003) begin failures++; $display("FAIL bp_hold cycle=%0d got v=%b d=%h exp v=1 d=0003", c, a_rsp1_valid, a_rsp1_data); end
            checks++; if (a_req0_ready !== 1'b0 || a_req1_ready !== 1'b0) begin failures++; $display("FAIL bp_ready cycle=%0d got=%b%b exp=00", c, a_req0_ready, a_req1_ready); end
            tick();
        end
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
        checks++; if (a_rsp1_valid !== 1'b0 || a_busy !== 1'b0) begin failures++; $display("FAIL bp_release got v=%b busy=%b exp 0 0", a_rsp1_valid, a_busy); end
        checks++; if (a_req0_ready !== 1'b1 || a_req1_ready !== 1'b0) begin failures++; $display("FAIL bp_rr_next got=%b%b exp=10", a_req0_ready, a_req1_ready); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_op();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_in1 = 16'hFF0F; req0_in2 = 16'h0FF0; req0_mode = 3'd4;
        req0_valid = 1'b1;
        tick();
        checks++; if (a_busy !== 1'b1 || a_alu_mode !== 3'd4) begin failures++; $display("FAIL mid_exec got busy=%b mode=%h exp 1 4", a_busy, a_alu_mode); end
        rst = 1'b1;
        tick();
        #1;
        checks++; if (a_busy !== 1'b0 || {a_alu_in1, a_alu_in2, a_alu_mode} !== 35'd0) begin failures++; $display("FAIL mid_reset_state got busy=%b alu=%h %h %h exp 0", a_busy, a_alu_in1, a_alu_in2, a_alu_mode); end
        checks++; if (a_rsp0_valid !== 1'b0 || a_rsp0_data !== 16'h0000 || a_rsp0_flags !== 16'h0000) begin failures++; $display("FAIL mid_reset_rsp got v=%b d=%h f=%h exp 0", a_rsp0_valid, a_rsp0_data, a_rsp0_flags); end
        checks++; if (a_req0_ready !== 1'b0) begin failures++; $display("FAIL mid_reset_ready got=%b exp=0", a_req0_ready); end
        rst = 1'b0;
        req0_valid = 1'b0;
        tick();
        tick();
        checks++; if (a_rsp0_valid !== 1'b0 || a_rsp1_valid !== 1'b0 || a_busy !== 1'b0) begin failures++; $display("FAIL mid_no_rsp got v=%b%b busy=%b exp 0", a_rsp0_valid, a_rsp1_valid, a_busy); end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_contention();
        test_fixed_prio();
        test_backpressure();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: FIXED_PRIO, default 0, 0 = round-robin grant, 1 = requester 0 always wins.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: req0_valid  input  1  requester 0 has an operation pending.
REQ-005 Port: req0_ready  output  1  arbiter accepts requester 0 operation this cycle.
REQ-006 Port: req0_in1, req0_in2  input  16 each  requester 0 operands.
REQ-007 Port: req0_mode  input  3  requester 0 ALU op code (0 ADD, 1 SUBST, 2 SHIFTR, 3 SHIFTL, 4 AND, 5 OR, 6 NOT, 7 XOR).
REQ-008 Port: req1_valid, req1_ready, req1_in1, req1_in2, req1_mode: same as REQ-004..007 for requester 1.
REQ-009 Port: alu_in1, alu_in2  output  16 each  registered operands driven to the shared ALU.
REQ-010 Port: alu_mode  output  3  registered op code driven to the shared ALU.
REQ-011 Port: alu_out  input  16  ALU result, combinational from alu_in1/alu_in2/alu_mode.
REQ-012 Port: alu_flags  input  16  ALU flags, captured unmodified.
REQ-013 Port: rsp0_valid  output  1  result for requester 0 available.
REQ-014 Port: rsp0_ready  input  1  requester 0 consumes result.
REQ-015 Port: rsp0_data, rsp0_flags  output  16 each  captured alu_out / alu_flags.
REQ-016 Port: rsp1_valid, rsp1_ready, rsp1_data, rsp1_flags: same as REQ-013..015 for requester 1.
REQ-017 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states: IDLE, EXEC, RESP, only.
REQ-019 IDLE: reqN_ready is high only for the granted requester, only when its valid is high, and depends combinationally on valid and the priority pointer.
REQ-020 Grant in IDLE: one valid requester wins. Both valid with FIXED_PRIO=0: the requester named by the rr pointer wins. Both valid with FIXED_PRIO=1: requester 0 wins.
REQ-021 Handshake (valid & ready) in IDLE: operands/mode latched into alu_in1/alu_in2/alu_mode, owner recorded, next state EXEC.
REQ-022 EXEC (exactly one cycle): alu_out and alu_flags captured into the owner's rsp data/flags registers, next state RESP.
REQ-023 RESP: owner's rspN_valid high; other rsp valid low; state holds until owner's rspN_ready is high.
REQ-024 RESP with rspN_ready high: next state IDLE, rspN_valid low next cycle, rr pointer set to the non-owner.
REQ-025 rr pointer changes only on RESP completion; a single requester is never starved while the other is continuously valid (FIXED_PRIO=0).
REQ-026 Latency: handshake at edge N, rsp valid from cycle N+2. Minimum issue interval: 3 cycles.
REQ-027 Both ready outputs are low in EXEC and RESP; valid inputs are ignored there.
REQ-028 alu_in*/alu_mode hold their values from the handshake until the next handshake.
REQ-029 rspN_data/flags hold the last captured value until overwritten by a later op for the same requester.
REQ-030 No arithmetic in the block; ALU values pass through unmodified, full 16-bit width.

Reset
REQ-031 rst high at a clock edge: state IDLE, rr pointer = requester 0, owner = 0; alu_in1, alu_in2, alu_mode, rsp*_data and rsp*_flags all 0; rsp*_valid 0; busy 0.
REQ-032 rst overrides everything: reset mid-EXEC or mid-RESP aborts the operation and emits no response.
REQ-033 ready outputs are low while rst is high.

Verification
REQ-034 Single op: req0 ADD in1=0x0003, in2=0x0004 -> alu_mode=0 and alu_in*=3/4 at N+1; rsp0_valid at N+2 with rsp0_data=0x0007; busy high for N+1..N+2.
REQ-035 Contention, FIXED_PRIO=0: both valid continuously after reset -> grants alternate req0, req1, req0, req1, one op per 3 cycles with rsp*_ready tied high.
REQ-036 FIXED_PRIO=1: both valid continuously -> req1 is never granted while req0_valid stays high.
REQ-037 Backpressure: req1 SUBST 0x0005-0x0002 with rsp1_ready low for 5 cycles -> rsp1_valid held high with data 0x0003; no ready issued to either requester until rsp1_ready rises.
REQ-038 Reset mid-op: rst asserted during EXEC -> next cycle all outputs at REQ-031 values; no rsp valid asserted.
REQ-039 Pass-through: alu_flags=0xA5A5 during EXEC -> rsp flags=0xA5A5 exactly.
